// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_buffered
//  Description : 8N1 UART transmitter with a single-entry holding buffer
//                allowing gapless back-to-back frames on TXD.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 27,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TXD,
    output logic       busy
);

    localparam int                 c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [2:0]         c_STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift;
    logic [7:0]           r_buf;
    logic [7:0]           w_buf;
    logic                 r_buf_full;
    logic                 w_buf_full;
    logic                 r_txd;
    logic                 w_txd;
    logic                 w_load;
    logic                 w_accept;
    logic                 w_bit_end;

    assign w_bit_end = (r_cnt == c_CNT_MAX);
    assign w_accept  = tx_valid & ~r_buf_full;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bit_idx  <= w_bit_idx;
            r_shift    <= w_shift;
            r_buf      <= w_buf;
            r_buf_full <= w_buf_full;
            r_txd      <= w_txd;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_bit_idx  = r_bit_idx;
        w_shift    = r_shift;
        w_buf      = r_buf;
        w_buf_full = r_buf_full;
        w_txd      = r_txd;
        w_load     = 1'b0;

        // The baud counter only runs while a frame is on the wire
        if (r_state == S_IDLE) begin
            w_cnt = '0;
        end else begin
            w_cnt = w_bit_end ? '0 : (r_cnt + c_CNT_ONE);
        end

        case (r_state)
            S_IDLE: begin
                w_txd = 1'b1;
                if (r_buf_full) begin
                    w_load  = 1'b1;
                    w_state = S_START;
                    w_txd   = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state   = S_DATA;
                    w_bit_idx = '0;
                    w_txd     = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state   = S_STOP;
                        w_bit_idx = '0;
                        w_txd     = 1'b1;
                    end else begin
                        w_bit_idx = r_bit_idx + 3'd1;
                        w_shift   = {1'b0, r_shift[7:1]};
                        w_txd     = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                w_txd = 1'b1;
                if (w_bit_end) begin
                    if (r_bit_idx == c_STOP_LAST) begin
                        w_bit_idx = '0;
                        // A waiting byte starts immediately: no idle gap
                        if (r_buf_full) begin
                            w_load  = 1'b1;
                            w_state = S_START;
                            w_txd   = 1'b0;
                        end else begin
                            w_state = S_IDLE;
                        end
                    end else begin
                        w_bit_idx = r_bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_txd   = 1'b1;
            end
        endcase

        // Load only happens with a full buffer and accept only with an empty one
        if (w_load) begin
            w_shift    = r_buf;
            w_buf_full = 1'b0;
        end else if (w_accept) begin
            w_buf      = tx_data;
            w_buf_full = 1'b1;
        end
    end

    assign tx_ready = ~r_buf_full;
    assign TXD      = r_txd;
    assign busy     = (r_state != S_IDLE) | r_buf_full;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_tx_buffered
//  Description : Scoreboard bench; a serial monitor decodes TXD frames and
//                compares them against bytes queued at accept time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int c_CPB = 27;
    localparam int c_FRAME = 10 * c_CPB;

    logic       CLK;
    logic       RST;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       TXD;
    logic       busy;

    int tests;
    int fails;
    int cyc;
    int acc_cyc;
    int last_fall;
    int prev_fall;
    int frames_rx;
    int frames_exp;
    logic [7:0] exp_q[$];

    uart_tx_buffered #(
        .CLKS_PER_BIT(c_CPB),
        .STOP_BITS   (1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .TXD     (TXD),
        .busy    (busy)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Serial monitor: samples mid-bit on falling clock edges
    initial begin : monitor
        bit         active;
        int         n;
        logic [7:0] rx;
        logic [7:0] e;
        active = 0;
        n = 0;
        rx = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                active = 0;
            end else if (!active) begin
                if (TXD == 1'b0) begin
                    active    = 1;
                    n         = 0;
                    prev_fall = last_fall;
                    last_fall = cyc;
                end
            end else begin
                n++;
                if (n == c_CPB / 2) begin
                    check("start_bit", int'(TXD), 0);
                end else if (n > c_CPB / 2 && (n - c_CPB / 2) % c_CPB == 0
                             && (n - c_CPB / 2) / c_CPB <= 8) begin
                    rx = {TXD, rx[7:1]};
                end else if (n == 9 * c_CPB + c_CPB / 2) begin
                    check("stop_bit", int'(TXD), 1);
                    frames_rx++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", int'(rx), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", int'(rx), int'(e));
                    end
                    active = 0;
                end
            end
        end
    end

    // Present a byte; returns at the falling edge after the accept edge
    task automatic send(input logic [7:0] b, input bit keep_valid);
        int waited;
        tx_data  = b;
        tx_valid = 1'b1;
        waited   = 0;
        while (!tx_ready && waited < 2000) begin
            @(negedge CLK);
            waited++;
        end
        if (!tx_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            acc_cyc = cyc;
            exp_q.push_back(b);
            frames_exp++;
            @(negedge CLK);
        end
        if (!keep_valid) tx_valid = 1'b0;
        tx_data = ~b;
    endtask

    task automatic wait_idle(output int t);
        int w;
        w = 0;
        while (busy && w < 4000) begin
            @(negedge CLK);
            w++;
        end
        t = cyc;
        if (busy) check("idle_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        int a1;
        int ones;
        tests = 0;
        fails = 0;
        cyc = 0;
        last_fall = 0;
        prev_fall = 0;
        frames_rx = 0;
        frames_exp = 0;
        tx_data = 8'h00;
        tx_valid = 1'b0;
        RST = 1'b0;

        // 1: reset
        #1 RST = 1'b1;
        #999;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_txd", int'(TXD), 1);
        check("rst_ready", int'(tx_ready), 1);
        check("rst_busy", int'(busy), 0);
        ones = 0;
        repeat (50) begin
            @(negedge CLK);
            ones += int'(TXD);
        end
        check("idle_txd_high", ones, 50);

        // 2: single byte with latency and busy timing
        send(8'h55, 0);
        wait_idle(t);
        check("latency", last_fall - acc_cyc, 2);
        check("busy_drop", t - last_fall, c_FRAME);
        repeat (5) @(negedge CLK);

        // 3: back-to-back, valid held high
        send(8'hA5, 1);
        a1 = acc_cyc;
        send(8'h3C, 0);
        check("second_accept", acc_cyc - a1, 2);
        wait_idle(t);
        check("gapless_start", last_fall - prev_fall, c_FRAME);
        repeat (5) @(negedge CLK);

        // 4: stall while buffer full
        send(8'h12, 0);
        send(8'h34, 0);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        repeat (20) @(negedge CLK);
        check("stall_ready", int'(tx_ready), 0);
        check("stall_busy", int'(busy), 1);
        send(8'h3C, 0);
        wait_idle(t);
        repeat (5) @(negedge CLK);

        // 5: asynchronous reset in the middle of bit 4
        send(8'hFF, 0);
        @(negedge CLK);
        while (cyc < last_fall + 5 * c_CPB + c_CPB / 2) @(negedge CLK);
        check("mid_busy", int'(busy), 1);
        #3 RST = 1'b1;
        #1;
        check("async_txd", int'(TXD), 1);
        check("async_ready", int'(tx_ready), 1);
        check("async_busy", int'(busy), 0);
        repeat (3) @(negedge CLK);
        exp_q.delete();
        frames_exp--;
        RST = 1'b0;
        ones = 0;
        repeat (300) begin
            @(negedge CLK);
            ones += int'(TXD);
        end
        check("no_resume", ones, 300);
        send(8'h00, 0);
        wait_idle(t);
        repeat (5) @(negedge CLK);

        // 6: loopback bytes through the serial monitor
        send(8'h00, 1);
        send(8'hFF, 1);
        send(8'h55, 1);
        send(8'hAA, 0);
        wait_idle(t);
        repeat (10) @(negedge CLK);

        check("queue_empty", exp_q.size(), 0);
        check("frame_count", frames_rx, frames_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
